// File: rtl/weight_pattern_gen.sv
// Enumerates every 7-bit word of popcount k in increasing order over a valid/ready stream.
// Optional: define WEIGHT_CHECK_EN to build the sticky popcount checker driving err.
module weight_pattern_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] k,
  output logic       busy,
  output logic [6:0] x,
  output logic       x_valid,
  input  logic       x_ready,
  output logic       x_last,
  output logic [5:0] count,
  output logic       done,
  output logic       err
);

  localparam int unsigned DW = 7;
  localparam int unsigned KW = 3;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   x_q, x_d;
  logic            x_valid_q, x_valid_d;
  logic            x_last_q, x_last_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;

  // Lowest word of weight kk: kk ones packed at the bottom.
  function automatic logic [DW-1:0] first_word(input logic [KW-1:0] kk);
    return DW'((8'd1 << kk) - 8'd1);
  endfunction

  // Highest word of weight kk: the same ones packed at the top.
  function automatic logic [DW-1:0] last_word(input logic [KW-1:0] kk);
    logic [7:0] f;
    f = {1'b0, first_word(kk)};
    return DW'(f << (3'd7 - kk));
  endfunction

  // Position of the single set bit of a one-hot byte.
  function automatic logic [2:0] tz8(input logic [7:0] c);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) t = 3'(i);
    end
    return t;
  endfunction

  // Next larger word with the same popcount, carried out at 8 bits.
  function automatic logic [DW-1:0] next_word(input logic [DW-1:0] w);
    logic [7:0] xx, c, r, n;
    xx = {1'b0, w};
    c  = xx & (~xx + 8'd1);
    r  = xx + c;
    n  = (((r ^ xx) >> 2) >> tz8(c)) | r;
    return DW'(n);
  endfunction

  logic [DW-1:0] nxt_c;
  assign nxt_c = next_word(x_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    x_last_d  = x_last_q;
    busy_d    = busy_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d    = 1'b0;
        x_valid_d = 1'b0;
        if (start) begin
          k_d       = k;
          x_d       = first_word(k);
          x_last_d  = (first_word(k) == last_word(k));
          count_d   = '0;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        if (x_valid_q && x_ready) begin
          count_d = count_q + CW'(1);
          if (x_last_q) begin
            x_valid_d = 1'b0;
            x_last_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            x_d      = nxt_c;
            x_last_d = (nxt_c == last_word(k_q));
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        x_valid_d = 1'b0;
        x_last_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

`ifdef WEIGHT_CHECK_EN
  // Sticky flag: any presented word whose popcount disagrees with the latched weight.
  function automatic logic [KW:0] popcount(input logic [DW-1:0] w);
    logic [KW:0] p;
    p = '0;
    for (int i = 0; i < int'(DW); i++) begin
      p = p + (KW+1)'(w[i]);
    end
    return p;
  endfunction

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (x_valid_q && (popcount(x_q) != {1'b0, k_q})) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy    = busy_q;
  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign x_last  = x_last_q;
  assign count   = count_q;
  assign done    = done_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Scoreboard bench for weight_pattern_gen: driver pushes the enumerated word list, monitor pops on handshakes.
module tb_weight_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] k;
  logic       busy;
  logic [6:0] x;
  logic       x_valid;
  logic       x_ready;
  logic       x_last;
  logic [5:0] count;
  logic       done;
  logic       err;

  weight_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .busy(busy), .x(x),
    .x_valid(x_valid), .x_ready(x_ready), .x_last(x_last), .count(count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] w;
    logic       last;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_count = 0;
  int   done_count = 0;
  int   done_cyc = 0;
  int   cyc_cnt = 0;
  int   exp_total = 0;
  bit   expect_done = 0;
  bit   stall_prev = 0;
  logic [6:0] stall_x;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: sampled on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (expect_done) begin
        chk("done_pulse", int'(done), 1);
        chk("busy_in_done", int'(busy), 1);
        chk("final_count", int'(count), exp_total);
        chk("err_clear", int'(err), 0);
        expect_done = 0;
        done_count++;
        done_cyc = cyc_cnt;
      end else if (done) begin
        chk("spurious_done", int'(done), 0);
      end
      if (stall_prev && x_valid) chk("hold_x", int'(x), int'(stall_x));
      if (x_valid && x_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", int'(x), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", int'(x), int'(e.w));
          chk("last_flag", int'(x_last), int'(e.last));
          chk("count_run", int'(count), e.idx);
          if (e.last) expect_done = 1;
        end
        hs_count++;
      end
      stall_prev = x_valid && !x_ready;
      stall_x    = x;
    end
  end

  // Reference: every 7-bit value with the requested popcount, ascending.
  task automatic push_expected(input int kk);
    int n;
    n = 0;
    for (int v = 0; v < 128; v++) begin
      if ($countones(v) == kk) n++;
    end
    exp_total = n;
    for (int v = 0, i = 0; v < 128; v++) begin
      if ($countones(v) == kk) begin
        exp_t e;
        e.w = 7'(v);
        e.idx = i;
        e.last = (i == n - 1);
        exp_q.push_back(e);
        i++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_x_valid"}, int'(x_valid), 0);
    chk({tag, "_x_last"}, int'(x_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // mode 0: ready held high; 1: ready toggles 1010..; 2: random ready. Modes 1/2 add start/k noise.
  task automatic run(input int kk, input int mode, input int rst_after);
    int  w, d0, h0, t0;
    bit  finished;
    w = 0;
    while (busy && w < 50) begin
      tick();
      w++;
    end
    if (busy) begin
      chk("idle_timeout", int'(busy), 0);
      return;
    end
    k = 3'(kk);
    start = 1'b1;
    x_ready = 1'b1;
    d0 = done_count;
    h0 = hs_count;
    tick();
    start = 1'b0;
    t0 = cyc_cnt;
    push_expected(kk);
    chk("busy_after_start", int'(busy), 1);
    chk("valid_after_start", int'(x_valid), 1);
    finished = 0;
    for (int c = 0; c < 600; c++) begin
      if (done_count != d0) begin
        finished = 1;
        break;
      end
      if (rst_after > 0 && (hs_count - h0) >= rst_after) begin
        rst = 1'b1;
        x_ready = 1'b0;
        start = 1'b0;
        exp_q.delete();
        expect_done = 0;
        tick();
        rst = 1'b0;
        check_reset_vals("midrun_rst");
        return;
      end
      case (mode)
        0:       x_ready = 1'b1;
        1:       x_ready = (c % 2 == 0);
        default: x_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) begin
        start = ($urandom_range(0, 3) == 0);
        k = 3'($urandom_range(0, 7));
      end
      tick();
    end
    start = 1'b0;
    x_ready = 1'($urandom_range(0, 1));
    if (!finished) chk("run_timeout", 0, 1);
    else if (mode == 0) chk("done_latency", done_cyc - t0, exp_total);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k = 3'd0;
    x_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");
    run(0, 0, 0);
    run(7, 0, 0);
    run(1, 0, 0);
    run(3, 0, 0);
    run(2, 1, 0);
    run(4, 0, 10);
    run(4, 0, 0);
    for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 7)), 2, 0);
    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_pattern_gen.md
# weight_pattern_gen

Sequential inverse of the population-count encoder: given a 3-bit weight `k`, it enumerates every 7-bit word whose popcount equals `k`, one word per handshake, in increasing numeric order. It drives exhaustive stimulus into the encoder/mux path and serves as the decode end of the weight-class interface. Output uses a valid/ready stream with a last marker, so the consumer can stall it.

## Interface
- No parameters; data width fixed at 7, weight width fixed at 3.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `k`  in  3  requested weight, 0..7; latched on accepted `start`.
- `busy`  out  1  high while a run is in progress (state != IDLE).
- `x`  out  7  current pattern; popcount(`x`) == latched `k`.
- `x_valid`  out  1  `x` is valid.
- `x_ready`  in  1  consumer accepts `x` when high together with `x_valid`.
- `x_last`  out  1  current `x` is the final word of the run.
- `count`  out  6  words accepted in the current run (max 35).
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `err`  out  1  sticky checker flag (see Configuration).

## Operation
- States: IDLE, EMIT, DONE.
- IDLE: `start`=1 latches `k` and loads `x` = (1<<k)-1, clears `count`, goes to EMIT. `start`=0 stays.
- EMIT: `x_valid`=1. On handshake (`x_valid`&`x_ready`): `count`+1; if `x_last`, go to DONE; else `x` <= next(`x`).
- next(x), computed at 8 bits to hold the carry: c = x & -x; r = x + c; next = (((r ^ x) >> 2) >> tz(c)) | r, where tz is the trailing-zero count. No divider is used.
- `x_last` = (`x` == ((1<<k)-1) << (7-k)); for k=0 and k=7 the first word is also the last.
- Words per run = C(7,k): 1,7,21,35,35,21,7,1 for k=0..7.
- DONE: `done`=1 for one cycle, then IDLE. `count` holds its final value until the next accepted `start`.
- `start` while `busy` is ignored; `k` changes while `busy` are ignored.
- Without handshake, `x`, `x_last`, `x_valid` and `count` stay stable.

## Timing
- Reset values: state IDLE, `x`=0, `x_valid`=0, `x_last`=0, `busy`=0, `count`=0, `done`=0, `err`=0.
- `start` accepted at edge N: `busy` and `x_valid` high from cycle N+1 with the first word.
- With `x_ready` held high: one word per cycle; last handshake at N+C(7,k); `done` at N+C(7,k)+1; `busy` stays high during the `done` cycle; the next `start` is accepted in the following cycle.
- `rst` mid-run: all outputs take their reset values at the next edge; the partial run is discarded.

## Configuration
- `WEIGHT_CHECK_EN` defined: combinational popcount of `x` is compared to the latched `k` whenever `x_valid`=1. A mismatch sets `err`, which holds until `rst`.
- Not defined: checker logic is not built and `err` is tied to 0.

## Test plan
- rst, start k=0, ready=1 -> single word 0000000 with `x_last`=1; `done` the next cycle; `count`=1.
- start k=7 -> single word 1111111 with `x_last`=1; `count`=1.
- start k=1, ready=1 -> 0000001, 0000010, … 1000000 on consecutive cycles; `x_last` only on 1000000; `count`=7.
- start k=3 at N, ready=1 -> 35 words, first 0000111, second 0001011, last 1110000 at N+35; `done` at N+36; `err`=0 with `WEIGHT_CHECK_EN`.
- start k=2, `x_ready` toggling 1010… -> `x` held while ready=0; accepted sequence 0000011, 0000101, 0000110, 0001001, …; `start` pulses during the run are ignored.
- start k=4, assert `rst` after 10 handshakes -> next cycle `x`=0, `x_valid`=0, `busy`=0, `count`=0; a new start k=4 begins again at 0001111.
